// File: rtl/nms_engine.sv
// Non-maximum suppression over a three-row gradient strip buffer.
// Each accepted strip shifts the row buffer; the middle row is then thinned one
// column per cycle against the neighbour pair its quantised angle selects.
module nms_engine #(
  parameter int unsigned OUT_W     = 12,
  parameter int unsigned MAG_W     = 8,
  parameter int unsigned THRESH_EN = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         anchor_moving,
  input  logic                         frame_start,
  input  logic [(OUT_W+2)*2-1:0]       gradient_angle,
  input  logic [(OUT_W+2)*MAG_W-1:0]   gradient_mag,
  input  logic [MAG_W-1:0]             low_thresh,
  output logic [OUT_W*MAG_W-1:0]       nms_out,
  output logic                         out_valid,
  output logic                         nms_final
);

  localparam int unsigned NCol = OUT_W + 2;
  localparam int unsigned IW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [IW-1:0] IdxLast = IW'(OUT_W - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StProc} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [1:0]       rows_q, rows_d;
  logic             out_valid_q, out_valid_d;
  logic [MAG_W-1:0] row0_q [NCol];
  logic [MAG_W-1:0] row1_q [NCol];
  logic [MAG_W-1:0] row2_q [NCol];
  logic [1:0]       ang0_q [NCol];
  logic [1:0]       ang1_q [NCol];
  logic [MAG_W-1:0] nms_q [OUT_W];
  logic [MAG_W-1:0] nms_d [OUT_W];

  logic             is_last;
  logic             load;
  logic [MAG_W-1:0] centre, nb_a, nb_b, result;
  logic             keep;

  // Edge columns of the middle-row angles never select a neighbour pair.
  logic unused_ang;
  assign unused_ang = ^{ang1_q[0], ang1_q[NCol-1]};

  assign is_last   = (state_q == StProc) && (idx_q == IdxLast);
  assign nms_final = (state_q == StIdle) || is_last;
  assign out_valid = out_valid_q;

  // Next-state, column index, row counter and valid pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (anchor_moving) state_d = StLoad;
      StLoad:  state_d = StProc;
      StProc:  if (is_last) state_d = anchor_moving ? StLoad : StIdle;
      default: state_d = StIdle;
    endcase

    load  = (state_d == StLoad);
    idx_d = (state_d == StProc && state_q == StProc) ? idx_q + 1'b1 : '0;

    rows_d = rows_q;
    if (load) begin
      if (frame_start)          rows_d = 2'd1;
      else if (rows_q != 2'd3)  rows_d = rows_q + 2'd1;
    end

    // Only a fully primed buffer yields a strip worth reporting.
    out_valid_d = is_last && (rows_q == 2'd3);
  end

  // Pick centre and neighbour pair for the current column and decide.
  always_comb begin
    centre = '0;
    nb_a   = '0;
    nb_b   = '0;
    for (int c = 0; c < OUT_W; c++) begin
      if (idx_q == IW'(c)) begin
        centre = row1_q[c+1];
        case (ang1_q[c+1])
          2'd0: begin nb_a = row1_q[c];   nb_b = row1_q[c+2]; end
          2'd1: begin nb_a = row0_q[c+2]; nb_b = row2_q[c];   end
          2'd2: begin nb_a = row0_q[c+1]; nb_b = row2_q[c+1]; end
          default: begin nb_a = row0_q[c]; nb_b = row2_q[c+2]; end
        endcase
      end
    end
    keep = (centre >= nb_a) && (centre >= nb_b);
    if (THRESH_EN != 0 && centre < low_thresh) keep = 1'b0;
    result = keep ? centre : '0;

    for (int c = 0; c < OUT_W; c++) begin
      nms_d[c] = nms_q[c];
      if (state_q == StProc && idx_q == IW'(c)) nms_d[c] = result;
    end
  end

  // Flatten the result strip onto the output bus.
  always_comb begin
    nms_out = '0;
    for (int c = 0; c < OUT_W; c++) nms_out[c*MAG_W +: MAG_W] = nms_q[c];
  end

  // State, counters, row buffer and results; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      rows_q      <= '0;
      out_valid_q <= 1'b0;
      for (int c = 0; c < NCol; c++) begin
        row0_q[c] <= '0;
        row1_q[c] <= '0;
        row2_q[c] <= '0;
        ang0_q[c] <= '0;
        ang1_q[c] <= '0;
      end
      for (int c = 0; c < OUT_W; c++) nms_q[c] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rows_q      <= rows_d;
      out_valid_q <= out_valid_d;
      for (int c = 0; c < OUT_W; c++) nms_q[c] <= nms_d[c];
      if (load) begin
        for (int c = 0; c < NCol; c++) begin
          row2_q[c] <= row1_q[c];
          row1_q[c] <= row0_q[c];
          row0_q[c] <= gradient_mag[c*MAG_W +: MAG_W];
          ang1_q[c] <= ang0_q[c];
          ang0_q[c] <= gradient_angle[c*2 +: 2];
        end
      end
    end
  end

endmodule

// File: tb/tb_nms_engine.sv
// Directed bench for nms_engine: reset, priming, peak/threshold/tie cases,
// streaming cadence and reset abort. Two instances differ only in THRESH_EN.
module tb_nms_engine;

  localparam int unsigned OW = 12;
  localparam int unsigned MW = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  anchor_moving = 1'b0;
  logic                  frame_start = 1'b0;
  logic [(OW+2)*2-1:0]   gradient_angle = '0;
  logic [(OW+2)*MW-1:0]  gradient_mag = '0;
  logic [MW-1:0]         low_thresh = '0;
  logic [OW*MW-1:0]      nms_out, nms_out_nt;
  logic                  out_valid, out_valid_nt;
  logic                  nms_final, nms_final_nt;

  int n_checks = 0;
  int n_bad    = 0;

  logic [MW-1:0] m_arr [OW+2];
  logic [1:0]    a_arr [OW+2];
  logic [MW-1:0] e_arr [OW];

  always #5 clk = ~clk;

  nms_engine #(.OUT_W(OW), .MAG_W(MW), .THRESH_EN(1)) dut (
    .clk(clk), .rst(rst), .anchor_moving(anchor_moving), .frame_start(frame_start),
    .gradient_angle(gradient_angle), .gradient_mag(gradient_mag), .low_thresh(low_thresh),
    .nms_out(nms_out), .out_valid(out_valid), .nms_final(nms_final)
  );

  nms_engine #(.OUT_W(OW), .MAG_W(MW), .THRESH_EN(0)) dut_nt (
    .clk(clk), .rst(rst), .anchor_moving(anchor_moving), .frame_start(frame_start),
    .gradient_angle(gradient_angle), .gradient_mag(gradient_mag), .low_thresh(low_thresh),
    .nms_out(nms_out_nt), .out_valid(out_valid_nt), .nms_final(nms_final_nt)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_arr();
    for (int c = 0; c < OW + 2; c++) begin
      m_arr[c] = '0;
      a_arr[c] = '0;
    end
    for (int c = 0; c < OW; c++) e_arr[c] = '0;
  endtask

  task automatic apply_row();
    for (int c = 0; c < OW + 2; c++) begin
      gradient_mag[c*MW +: MW] = m_arr[c];
      gradient_angle[c*2 +: 2] = a_arr[c];
    end
  endtask

  function automatic logic [OW*MW-1:0] exp_vec();
    logic [OW*MW-1:0] v;
    for (int c = 0; c < OW; c++) v[c*MW +: MW] = e_arr[c];
    return v;
  endfunction

  // One strip accepted from IDLE; checks the valid pulse and nms_final timing.
  task automatic run_strip(input logic fs, input logic pulse);
    @(negedge clk);
    apply_row();
    anchor_moving = 1'b1;
    frame_start   = fs;
    @(posedge clk);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) begin
        anchor_moving = 1'b0;
        frame_start   = 1'b0;
      end
      check_eq($sformatf("strip_valid_t%0d", i), 128'(out_valid), 128'(pulse && i == 14));
      if (i == 12 || i == 13)
        check_eq($sformatf("strip_final_t%0d", i), 128'(nms_final), 128'(i == 13));
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_final", 128'(nms_final), 128'(1));
    check_eq("rst_final_nt", 128'(nms_final_nt), 128'(1));
    check_eq("rst_valid", 128'(out_valid), 128'(0));
    check_eq("rst_valid_nt", 128'(out_valid_nt), 128'(0));
    check_eq("rst_nms", 128'(nms_out), 128'(0));

    // Priming: A (frame start), B (horizontal peak), C (threshold/tie data)
    clear_arr();
    run_strip(1'b1, 1'b0);

    clear_arr();
    m_arr[5] = 8'd100; m_arr[6] = 8'd200; m_arr[7] = 8'd100; m_arr[9] = 8'd10;
    run_strip(1'b0, 1'b0);

    clear_arr();
    m_arr[2] = 8'd10; m_arr[3] = 8'd20; m_arr[4] = 8'd10;
    m_arr[8] = 8'd50; a_arr[8] = 2'd3;
    m_arr[10] = 8'd50; a_arr[10] = 2'd1;
    run_strip(1'b0, 1'b1);

    // Row1 was strip B
    clear_arr();
    e_arr[5] = 8'd200; e_arr[8] = 8'd10;
    check_eq("peak_k5", 128'(nms_out[5*MW +: MW]), 128'(200));
    check_eq("peak_k4", 128'(nms_out[4*MW +: MW]), 128'(0));
    check_eq("peak_k6", 128'(nms_out[6*MW +: MW]), 128'(0));
    check_eq("peak_vec", 128'(nms_out), 128'(exp_vec()));
    check_eq("peak_vec_nt", 128'(nms_out_nt), 128'(exp_vec()));

    // Strip D; row1 becomes C with low_thresh 30
    low_thresh = 8'd30;
    clear_arr();
    m_arr[7] = 8'd50; m_arr[11] = 8'd60;
    run_strip(1'b0, 1'b1);
    check_eq("thresh_k2", 128'(nms_out[2*MW +: MW]), 128'(0));
    check_eq("thresh_k2_nt", 128'(nms_out_nt[2*MW +: MW]), 128'(20));
    check_eq("tie_a3_k7", 128'(nms_out[7*MW +: MW]), 128'(50));
    check_eq("a1_k9", 128'(nms_out[9*MW +: MW]), 128'(0));
    clear_arr();
    e_arr[7] = 8'd50;
    check_eq("thresh_vec", 128'(nms_out), 128'(exp_vec()));
    e_arr[2] = 8'd20;
    check_eq("thresh_vec_nt", 128'(nms_out_nt), 128'(exp_vec()));

    // Streaming: five strips, anchor held high, peak of strip s at col s+1
    @(negedge clk);
    rst = 1'b1;
    low_thresh = '0;
    @(negedge clk);
    rst = 1'b0;
    clear_arr();
    m_arr[2] = 8'd40;
    apply_row();
    anchor_moving = 1'b1;
    frame_start   = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      check_eq($sformatf("stream_valid_t%0d", i), 128'(out_valid),
               128'(i == 40 || i == 53 || i == 66));
      check_eq($sformatf("stream_final_t%0d", i), 128'(nms_final),
               128'((i % 13 == 0) || i >= 66));
      if (i == 40 || i == 53 || i == 66) begin
        clear_arr();
        e_arr[(i - 14) / 13] = MW'(40 * ((i - 14) / 13));
        check_eq($sformatf("stream_nms_t%0d", i), 128'(nms_out), 128'(exp_vec()));
      end
      if (i == 1) frame_start = 1'b0;
      if (i % 13 == 0 && i <= 52) begin
        clear_arr();
        m_arr[i / 13 + 2] = MW'(40 * (i / 13 + 1));
        apply_row();
      end
      if (i == 53) anchor_moving = 1'b0;
    end

    // Reset at PROC index 5, with anchor_moving also high
    clear_arr();
    m_arr[1] = 8'd99;
    apply_row();
    anchor_moving = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) anchor_moving = 1'b0;
      if (i == 6) check_eq("pre_rst_nms", 128'(nms_out != '0), 128'(1));
      if (i == 7) begin
        rst = 1'b1;
        anchor_moving = 1'b1;
      end else if (i == 8) begin
        check_eq("midrst_nms", 128'(nms_out), 128'(0));
        check_eq("midrst_valid", 128'(out_valid), 128'(0));
        check_eq("midrst_final", 128'(nms_final), 128'(1));
        rst = 1'b0;
        anchor_moving = 1'b0;
      end else if (i > 8) begin
        check_eq($sformatf("post_rst_valid_t%0d", i), 128'(out_valid), 128'(0));
        check_eq($sformatf("post_rst_final_t%0d", i), 128'(nms_final), 128'(1));
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/nms_engine.md
NMS_ENGINE -- requirements
Module: nms_engine

Interface
REQ-001 SHALL have parameter OUT_W, default 12: output pixels per strip, minimum 1.
REQ-002 SHALL have parameter MAG_W, default 8: gradient magnitude width in bits, unsigned.
REQ-003 SHALL have parameter THRESH_EN, default 1: 1 enables low-threshold suppression.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port anchor_moving, input, 1 bit: a new strip row is present on the gradient inputs.
REQ-008 SHALL have port frame_start, input, 1 bit: qualifies anchor_moving as the first row of a frame.
REQ-009 SHALL have port gradient_angle, input, (OUT_W+2)x2 bits: quantised angle per column.
REQ-010 SHALL have port gradient_mag, input, (OUT_W+2)xMAG_W bits: magnitude per column.
REQ-011 SHALL have port low_thresh, input, MAG_W bits: suppression threshold, sampled in PROC.
REQ-012 SHALL have port nms_out, output, OUT_W x MAG_W bits: registered thinned strip.
REQ-013 SHALL have port out_valid, output, 1 bit: one-cycle pulse when nms_out holds a complete valid strip.
REQ-014 SHALL have port nms_final, output, 1 bit: combinational; high in IDLE or on the last PROC cycle.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD and PROC.
REQ-016 FSM transitions SHALL be:
  - IDLE->LOAD when anchor_moving=1, else stay in IDLE.
  - LOAD->PROC unconditionally.
  - PROC->LOAD when nms_final=1 and anchor_moving=1.
  - PROC->IDLE when nms_final=1 and anchor_moving=0.
  - PROC->PROC otherwise.
REQ-017 SHALL keep a 3-row buffer (row0 newest, row2 oldest) and shift it on the edge where next_state becomes LOAD: row2<=row1, row1<=row0, row0<=inputs.
REQ-018 SHALL ignore anchor_moving in LOAD and in every PROC cycle except the last; there is no backpressure.
REQ-019 SHALL keep a 2-bit rows_loaded counter that saturates at 3 and increments on each load; a load with frame_start=1 SHALL set it to 1.
REQ-020 SHALL use an index counter of width $clog2(OUT_W) (minimum 1): cleared whenever next_state != PROC, incremented each PROC cycle, with final value OUT_W-1.
REQ-021 For PROC index k, the centre SHALL be row1 column k+1 and the angle SHALL be row1 angle column k+1.
REQ-022 Neighbour pairs by angle code SHALL be:
  - 0: (row1[k], row1[k+2]).
  - 1: (row0[k+2], row2[k]).
  - 2: (row0[k+1], row2[k+1]).
  - 3: (row0[k], row2[k+2]).
REQ-023 The centre SHALL be kept if it is >= both neighbours (unsigned MAG_W compare, ties kept), otherwise the result is 0.
REQ-024 If THRESH_EN=1 and centre < low_thresh, the result SHALL be 0 regardless of REQ-023.
REQ-025 SHALL write nms_out[k] on the edge ending PROC cycle k; other entries are unchanged.
REQ-026 Latency: with anchor_moving accepted in cycle T, LOAD SHALL occur in T+1 and PROC in T+2..T+OUT_W+1.
REQ-027 out_valid SHALL be registered, high only in cycle T+OUT_W+2, and only if rows_loaded==3 during PROC.
REQ-028 With anchor_moving held high, a strip SHALL be loaded every OUT_W+1 cycles with no strip dropped; the out_valid pulse SHALL coincide with the next LOAD.

Reset
REQ-029 While rst=1 at a clock edge, state SHALL go to IDLE, and index, rows_loaded, row buffer, nms_out and out_valid SHALL be cleared to 0.
REQ-030 nms_final SHALL read 1 on the cycle after reset.
REQ-031 Reset asserted mid-PROC SHALL abort the strip with no out_valid pulse.
REQ-032 rst SHALL take priority over anchor_moving in the same cycle.

Verification
REQ-033 Reset mid-PROC: assert rst at index=5 -> next cycle nms_out=0, out_valid=0, nms_final=1, state IDLE.
REQ-034 Priming: three loads, first with frame_start=1 -> out_valid pulses only after the third strip, at T+14 for OUT_W=12.
REQ-035 Horizontal peak: row1 column 6=200, columns 5 and 7=100, angle 0, low_thresh=0 -> nms_out[5]=200, nms_out[4]=0, nms_out[6]=0.
REQ-036 Threshold: centre 20 as local maximum, low_thresh=30 -> output 0; same stimulus with THRESH_EN=0 -> output 20.
REQ-037 Ties and diagonals: centre 50, angle-3 neighbours 50 and 10 -> output 50; angle-1 neighbour 60 -> output 0.
REQ-038 Streaming: anchor_moving held high for 5 strips -> LOAD every 13 cycles, 3 out_valid pulses, no dropped rows.
